// File: rtl/gf_row_sequencer_pkg.sv
// gf_row_sequencer_pkg: shared field degree, FSM states and default polynomial
package gf_row_sequencer_pkg;
  localparam int M = 8;
  localparam logic [8:1] G_AES = 8'h1B;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/gf_row_step.sv
// gf_row_step: one MSB-first GF(2^M) multiply step, acc*x mod g plus bit*a
module gf_row_step #(
  parameter int M = 8
) (
  input  logic [M:1] a,
  input  logic [M:1] g,
  input  logic [M:1] acc,
  input  logic       b_bit,
  output logic [M:1] acc_nxt
);
  always_comb acc_nxt = ({M{b_bit}} & a) ^ ({M{acc[M]}} & g) ^ {acc[M-1:1], 1'b0};
endmodule

// File: rtl/gf_row_sequencer.sv
// gf_row_sequencer: bit-serial GF(2^M) multiplier, one multiplier bit per cycle
module gf_row_sequencer
  import gf_row_sequencer_pkg::*;
#(
  parameter int M = gf_row_sequencer_pkg::M
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [M:1] a,
  input  logic [M:1] b,
  input  logic [M:1] g,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [M:1] p,
  output logic       busy
);
  localparam int CW = $clog2(M + 1);
  state_e        state_q, state_d;
  logic [M:1]    a_q, a_d, g_q, g_d, bs_q, bs_d, acc_q, acc_d, acc_step;
  logic [CW-1:0] cnt_q, cnt_d;
  gf_row_step #(.M(M)) u_step (
    .a      (a_q),
    .g      (g_q),
    .acc    (acc_q),
    .b_bit  (bs_q[M]),
    .acc_nxt(acc_step)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    g_d     = g_q;
    bs_d    = bs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d     = a;
      g_d     = g;
      bs_d    = b;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      acc_d   = acc_step;
      bs_d    = {bs_q[M-1:1], 1'b0};
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(M - 1)) ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      g_q     <= '0;
      bs_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      g_q     <= g_d;
      bs_q    <= bs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    p         = out_valid ? acc_q : '0;
  end
endmodule

// File: tb/tb_gf_row_sequencer.sv
// tb_gf_row_sequencer: random and directed checks against a GF(2^8) software model
module tb_gf_row_sequencer;
  import gf_row_sequencer_pkg::*;
  localparam int W = 8;
  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic         in_ready, out_valid, busy;
  logic [W:1]   a = 0, b = 0, g = 0, p;
  int           checks = 0, failures = 0;
  gf_row_sequencer #(.M(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .g(g), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W:1] gf_mul(input logic [W:1] x, input logic [W:1] y, input logic [W:1] poly);
    logic [W:1] r = 0;
    for (int i = 1; i <= W; i++) begin
      if (y[i]) r ^= x;
      x = x[W] ? ((x << 1) ^ poly) : (x << 1);
    end
    return r;
  endfunction
  task automatic do_op(input logic [W:1] ai, input logic [W:1] bi, input logic [W:1] gi,
                       input int hold, input bit scramble);
    logic [W:1] exp = gf_mul(ai, bi, gi);
    int n = 0;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ai; b = bi; g = gi; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && n < 20) begin
      check("busy_run", busy, 1);
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); g = W'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    check("latency", n, W);
    check("product", p, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_p", p, exp);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    check("drain_valid", out_valid, 0);
    check("drain_p", p, 0);
    check("drain_busy", busy, 0);
  endtask
  initial begin
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    do_op(8'h57, 8'h83, G_AES, 5, 0);
    check("known_c1", gf_mul(8'h57, 8'h83, G_AES), 8'hC1);
    do_op(8'h57, 8'h13, G_AES, 0, 1);
    do_op(8'hA5, 8'h01, G_AES, 1, 0);
    do_op(8'h00, 8'hFF, G_AES, 0, 1);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; g = G_AES; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_p", p, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_pulse", out_valid, 0);
      if (i == 2) rst_n = 1;
    end
    do_op(8'h02, 8'h80, G_AES, 0, 0);
    for (int t = 0; t < 1000; t++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom);
      end
      do_op(W'($urandom), W'($urandom), ($urandom_range(0, 1) != 0) ? G_AES : W'($urandom),
            $urandom_range(0, 4), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gf_row_sequencer.md
GF_ROW_SEQUENCER -- requirements
Module: gf_row_sequencer

Interface
REQ-001 Parameter M, default 8, field degree; operand and polynomial width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set present on a, b, g.
REQ-005 in_ready  output  1  sequencer can accept an operand set.
REQ-006 a  input  [M:1]  multiplicand, a[1] = coefficient of x^0.
REQ-007 b  input  [M:1]  multiplier, b[M] = coefficient of x^(M-1), consumed MSB-first.
REQ-008 g  input  [M:1]  field polynomial without implicit x^M term, g[1] = x^0 coefficient.
REQ-009 out_valid  output  1  product on p is valid.
REQ-010 out_ready  input  1  consumer accepts p.
REQ-011 p  output  [M:1]  product a*b mod (x^M + g), p[1] = x^0 coefficient.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; the transfer occurs on an edge with in_valid && in_ready.
REQ-015 On transfer: latch a, g into holding registers; load b into shift register bs; clear accumulator acc to 0; clear counter cnt to 0; go to RUN.
REQ-016 Each RUN cycle: bit = bs[M]; ti = acc[M]; acc[k] <= (bit & a[k]) ^ (ti & g[k]) ^ acc[k-1] for k = 2..M; acc[1] <= (bit & a[1]) ^ (ti & g[1]); bs shifts left one bit, zero-filled; cnt increments.
REQ-017 RUN SHALL last exactly M cycles; the edge that performs step M moves the FSM to DONE.
REQ-018 Latency: out_valid rises M edges after the transfer edge (rises on the edge that performs step M).
REQ-019 In DONE: out_valid = 1 and p = acc, both held stable until out_ready is sampled high.
REQ-020 DONE with out_ready = 1: go to IDLE; out_valid falls on that edge.
REQ-021 in_ready is 0 in DONE, so in_valid coincident with out_ready is not accepted until the following IDLE cycle; there is no back-to-back bypass.
REQ-022 Changes on a, b, g, or in_valid outside the transfer edge SHALL have no effect on the result.
REQ-023 p SHALL be driven 0 whenever out_valid = 0.
REQ-024 cnt width is ceil(log2(M+1)); cnt never wraps within a run.
REQ-025 Arithmetic is GF(2) only: XOR/AND, no carries.

Reset
REQ-026 While rst_n = 0: state = IDLE; acc, bs, cnt, and the a/g holding registers are 0; out_valid = 0; p = 0; busy = 0; in_ready = 1 once rst_n is released.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; the first operand set after release is processed normally.

Structure
REQ-028 A shared package holds M, the state enumeration, and the AES default polynomial constant G_AES = 0x1B.
REQ-029 One combinational sub-module, gf_row_step, implements REQ-016 for one step (inputs a, g, acc, bit; output next acc); the sequencer instantiates it once.
REQ-030 The design SHALL contain no latches and no combinational path from in_valid to in_ready or from out_ready to out_valid.

Verification
REQ-031 M=8, g=0x1B, a=0x57, b=0x83 -> p=0xC1, out_valid 8 cycles after transfer.
REQ-032 g=0x1B, a=0x57, b=0x13 -> p=0xFE; a=0xA5, b=0x01 -> p=0xA5; a=0x00, b=0xFF -> p=0x00.
REQ-033 Hold out_ready=0 for 5 cycles after out_valid -> p and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-034 Change a and b every cycle during RUN -> result equals the product of the values latched at transfer.
REQ-035 Assert rst_n=0 at RUN step 4 -> all outputs 0 immediately, no out_valid pulse; then a=0x02, b=0x80 -> p=0x1B.
REQ-036 Random 1000 transfers vs. a software GF(2^8) model, with random in_valid/out_ready gaps -> zero mismatches and no lost or duplicated results.
